countdown_ctrl: RTL

//  MM:SS countdown timer controller for the lab display path. Sequences a chain of

---
 rtl/countdown_pkg.sv | 18 +
 rtl/countdown_if.sv | 21 ++
 rtl/cd_digit.sv | 31 +++
 rtl/countdown_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown controller.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LIM_SEC_ONES = 4'd9;
  localparam logic [3:0] LIM_SEC_TENS = 4'd5;
  localparam logic [3:0] LIM_MIN      = 4'd9;

  localparam logic [3:0] DIGIT_ZERO = 4'd0;
  localparam logic [7:0] BCD_ZERO   = 8'h00;

endpackage

// File: rtl/countdown_if.sv
// Control and display bundle of the countdown controller; master drives buttons/tick.
interface countdown_if;
  logic       tick;
  logic       start_pause;
  logic       clear;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output tick, start_pause, clear,
    input  min_bcd, sec_bcd, running, done, alarm
  );

  modport slave (
    input  tick, start_pause, clear,
    output min_bcd, sec_bcd, running, done, alarm
  );
endinterface

// File: rtl/cd_digit.sv
// One BCD down-counting digit: reloads its limit and borrows when decremented at 0.
module cd_digit
  import countdown_pkg::*;
#(
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] limit,
  output logic [3:0] val,
  output logic       borrow
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the borrow chain resolves in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= RST_VAL;
    end else if (load) begin
      val <= load_val;
    end else if (dec) begin
      val <= (val == DIGIT_ZERO) ? limit : val - 4'd1;
    end
  end

  assign borrow = dec && (val == DIGIT_ZERO);

endmodule

// File: rtl/countdown_ctrl.sv
// MM:SS countdown controller: start/pause/done FSM over four BCD down-digits.
// Optional alarm strobe built only when COUNTDOWN_ALARM_EN is defined.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter logic [7:0] INIT_MIN    = 8'h01,
  parameter logic [7:0] INIT_SEC    = 8'h30,
  parameter int         ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  countdown_if.slave bus
);

  localparam bit INIT_ZERO = (INIT_MIN == BCD_ZERO) && (INIT_SEC == BCD_ZERO);

  state_t     state;
  logic [3:0] borrow;
  logic       dec_en;
  logic       at_one;
  logic       go_done;
  logic       unused_borrow;

  // Clear and start_pause both outrank tick, so either suppresses the decrement.
  assign dec_en  = (state == ST_RUN) && bus.tick && !bus.start_pause && !bus.clear;
  assign at_one  = (bus.min_bcd == BCD_ZERO) && (bus.sec_bcd == 8'h01);
  assign go_done = !bus.clear &&
                   (((state == ST_IDLE) && bus.start_pause && INIT_ZERO) ||
                    (dec_en && at_one));
  assign unused_borrow = borrow[3];

  cd_digit #(.RST_VAL(INIT_SEC[3:0])) u_sec_ones (
    .clk, .rst, .dec(dec_en), .load(bus.clear), .load_val(INIT_SEC[3:0]),
    .limit(LIM_SEC_ONES), .val(bus.sec_bcd[3:0]), .borrow(borrow[0])
  );

  cd_digit #(.RST_VAL(INIT_SEC[7:4])) u_sec_tens (
    .clk, .rst, .dec(borrow[0]), .load(bus.clear), .load_val(INIT_SEC[7:4]),
    .limit(LIM_SEC_TENS), .val(bus.sec_bcd[7:4]), .borrow(borrow[1])
  );

  cd_digit #(.RST_VAL(INIT_MIN[3:0])) u_min_ones (
    .clk, .rst, .dec(borrow[1]), .load(bus.clear), .load_val(INIT_MIN[3:0]),
    .limit(LIM_MIN), .val(bus.min_bcd[3:0]), .borrow(borrow[2])
  );

  cd_digit #(.RST_VAL(INIT_MIN[7:4])) u_min_tens (
    .clk, .rst, .dec(borrow[2]), .load(bus.clear), .load_val(INIT_MIN[7:4]),
    .limit(LIM_MIN), .val(bus.min_bcd[7:4]), .borrow(borrow[3])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (bus.clear) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start_pause) state <= INIT_ZERO ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (bus.start_pause) state <= ST_PAUSE;
          else if (go_done)    state <= ST_DONE;
        end
        ST_PAUSE: if (bus.start_pause) state <= ST_RUN;
        default:  state <= ST_DONE;
      endcase
    end
  end

  assign bus.running = (state == ST_RUN);
  assign bus.done    = (state == ST_DONE);

`ifdef COUNTDOWN_ALARM_EN
  localparam int ACW = $clog2(ALARM_TICKS + 1);

  logic [ACW-1:0] alarm_cnt;
  logic           alarm_q;

  // Entering DONE takes precedence, so the tick that caused it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (bus.clear) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (go_done) begin
      alarm_q   <= 1'b1;
      alarm_cnt <= '0;
    end else if (alarm_q && bus.tick) begin
      alarm_cnt <= alarm_cnt + 1'b1;
      if (alarm_cnt == ACW'(ALARM_TICKS - 1)) alarm_q <= 1'b0;
    end
  end

  assign bus.alarm = alarm_q;
`else
  localparam int unused_alarm_ticks = ALARM_TICKS;
  assign bus.alarm = 1'b0;
`endif

endmodule
